// File: rtl/riscv_muldiv_pkg.sv
// Shared types and constants for the iterative RV32M/RV64M multiply/divide unit.
package riscv_muldiv_pkg;

  // Operation encoding matches Funct3 of the OP-class M-extension instructions.
  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } md_state_e;

  localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

  // Map Funct3 onto the operation enum.
  function automatic md_op_e decode_md_op(input logic [2:0] funct3);
    md_op_e op;
    case (funct3)
      3'b000:  op = MUL;
      3'b001:  op = MULH;
      3'b010:  op = MULHSU;
      3'b011:  op = MULHU;
      3'b100:  op = DIV;
      3'b101:  op = DIVU;
      3'b110:  op = REM;
      default: op = REMU;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/riscv_muldiv_if.sv
// Issue/result handshake bundle for riscv_muldiv_unit.
// master = EX-stage issuer/consumer, slave = the multiply/divide unit.
interface riscv_muldiv_if #(
  parameter int XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            flush_i;
  logic            valid_o;
  logic            ready_i;
  logic [XLEN-1:0] result_o;
  logic            illegal_o;
  logic            busy_o;

  modport master (
    output valid_i, funct3, funct7, op_a, op_b, flush_i, ready_i,
    input  ready_o, valid_o, result_o, illegal_o, busy_o
  );

  modport slave (
    input  valid_i, funct3, funct7, op_a, op_b, flush_i, ready_i,
    output ready_o, valid_o, result_o, illegal_o, busy_o
  );

endinterface

// File: rtl/riscv_muldiv_decode.sv
// Combinational Funct3/Funct7 decode for the multiply/divide unit.
// want_high selects the upper half of the product register: MULH* high
// product bits, or the remainder for REM/REMU.
module riscv_muldiv_decode
  import riscv_muldiv_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output md_op_e     op,
  output logic       a_signed,
  output logic       b_signed,
  output logic       is_div,
  output logic       want_high,
  output logic       illegal
);

  // Derive signedness and result-half selection from the operation.
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    op        = decode_md_op(funct3);
    illegal   = (funct7 != MULDIV_FUNCT7);
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    is_div    = 1'b0;
    want_high = 1'b0;
    case (op)
      MUL:    ;
      MULH:   begin a_signed = 1'b1; b_signed = 1'b1; want_high = 1'b1; end
      MULHSU: begin a_signed = 1'b1; want_high = 1'b1; end
      MULHU:  want_high = 1'b1;
      DIV:    begin a_signed = 1'b1; b_signed = 1'b1; is_div = 1'b1; end
      DIVU:   is_div = 1'b1;
      REM:    begin a_signed = 1'b1; b_signed = 1'b1; is_div = 1'b1; want_high = 1'b1; end
      REMU:   begin is_div = 1'b1; want_high = 1'b1; end
      default: ;
    endcase
  end

endmodule

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: shift-add multiply and
// restoring divide over XLEN cycles on absolute values, sign fixed up on
// entry to DONE. Optional macro MULDIV_EARLY_OUT_EN lets divide-by-zero,
// signed overflow and multiply-by-zero skip BUSY and finish in one cycle.
module riscv_muldiv_unit
  import riscv_muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  riscv_muldiv_if.slave     io
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] XLEN_MIN = {1'b1, {(XLEN-1){1'b0}}};

  // Decoded view of the instruction currently on the issue port.
  md_op_e dec_op;
  logic   dec_a_signed, dec_b_signed, dec_is_div, dec_want_high, dec_illegal;

  riscv_muldiv_decode u_decode (
    .funct3    (io.funct3),
    .funct7    (io.funct7),
    .op        (dec_op),
    .a_signed  (dec_a_signed),
    .b_signed  (dec_b_signed),
    .is_div    (dec_is_div),
    .want_high (dec_want_high),
    .illegal   (dec_illegal)
  );

  md_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     prod_q, prod_d;
  logic [XLEN-1:0]       divisor_q, divisor_d;
  md_op_e                op_q, op_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       result_q, result_d;
  logic                  illegal_q, illegal_d;

  logic                  accept;
  logic                  a_neg, b_neg, div_by_zero;
  logic [XLEN-1:0]       a_abs, b_abs;
  logic                  early_hit;
  logic [XLEN-1:0]       early_res;

  assign accept = io.valid_i && io.ready_o;

  // Operand sign extraction and magnitudes taken at accept.
  always_comb begin
    a_neg       = dec_a_signed && io.op_a[XLEN-1];
    b_neg       = dec_b_signed && io.op_b[XLEN-1];
    a_abs       = a_neg ? (~io.op_a + 1'b1) : io.op_a;
    b_abs       = b_neg ? (~io.op_b + 1'b1) : io.op_b;
    div_by_zero = (io.op_b == '0);
  end

`ifdef MULDIV_EARLY_OUT_EN
  // Architecturally defined or trivially zero results resolved at accept.
  always_comb begin
    early_hit = 1'b0;
    early_res = '0;
    if (dec_is_div) begin
      if (div_by_zero) begin
        early_hit = 1'b1;
        early_res = dec_want_high ? io.op_a : '1;
      end else if (dec_a_signed && io.op_a == XLEN_MIN && io.op_b == '1) begin
        early_hit = 1'b1;
        early_res = dec_want_high ? '0 : io.op_a;
      end
    end else if (io.op_a == '0 || io.op_b == '0) begin
      early_hit = 1'b1;
      early_res = '0;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  // One iteration of the shared datapath. Multiply: upper half accumulates,
  // multiplier bits shift out of the lower half. Divide: upper half holds the
  // partial remainder, lower half shifts dividend bits out and quotient bits in.
  logic              step_is_div;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift, div_diff;
  logic              div_borrow;
  logic [XLEN-1:0]   div_rem;
  logic [2*XLEN-1:0] step;

  always_comb begin
    step_is_div = op_q inside {DIV, DIVU, REM, REMU};
    mul_sum     = {1'b0, prod_q[2*XLEN-1:XLEN]} +
                  (prod_q[0] ? {1'b0, divisor_q} : '0);
    div_shift   = prod_q[2*XLEN-1:XLEN-1];
    div_diff    = div_shift - {1'b0, divisor_q};
    div_borrow  = div_diff[XLEN];
    div_rem     = div_borrow ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    step        = step_is_div ? {div_rem, prod_q[XLEN-2:0], ~div_borrow}
                              : {mul_sum, prod_q[XLEN-1:1]};
  end

  // Final result selection and conditional negation from the last iteration.
  logic [2*XLEN-1:0] mul_full;
  logic [XLEN-1:0]   div_sel;
  logic [XLEN-1:0]   fin;

  always_comb begin
    mul_full = neg_q ? (~step + 1'b1) : step;
    div_sel  = (op_q inside {REM, REMU}) ? step[2*XLEN-1:XLEN] : step[XLEN-1:0];
    case (op_q)
      MUL:                 fin = mul_full[XLEN-1:0];
      MULH, MULHSU, MULHU: fin = mul_full[2*XLEN-1:XLEN];
      default:             fin = neg_q ? (~div_sel + 1'b1) : div_sel;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state is updated with <= so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic; flush overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (dec_illegal || early_hit) ? DONE : BUSY;
      BUSY: if (cnt_q == CNT_W'(1)) state_d = DONE;
      DONE: if (io.ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (io.flush_i) state_d = IDLE;
  end

  // FSM outputs.
  always_comb begin
    io.ready_o   = (state_q == IDLE) && !io.flush_i;
    io.valid_o   = (state_q == DONE);
    io.busy_o    = (state_q != IDLE);
    io.result_o  = result_q;
    io.illegal_o = illegal_q;
  end

  // Datapath next-state: latch operands on accept, iterate in BUSY,
  // capture the signed-corrected result on the last iteration.
  always_comb begin
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    divisor_d = divisor_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d      = dec_op;
          illegal_d = dec_illegal;
          prod_d    = {{XLEN{1'b0}}, a_abs};
          divisor_d = b_abs;
          // Remainder follows the dividend; a zero divisor keeps the
          // all-ones quotient unnegated.
          if (dec_is_div)
            neg_d = dec_want_high ? a_neg : ((a_neg ^ b_neg) && !div_by_zero);
          else
            neg_d = a_neg ^ b_neg;
          if (dec_illegal) begin
            result_d = '0;
          end else if (early_hit) begin
            result_d = early_res;
          end else begin
            cnt_d = CNT_W'(XLEN);
          end
        end
      end
      BUSY: begin
        prod_d = step;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) result_d = fin;
      end
      default: ;
    endcase
    if (io.flush_i) cnt_d = '0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      prod_q    <= '0;
      divisor_q <= '0;
      op_q      <= MUL;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      prod_q    <= prod_d;
      divisor_q <= divisor_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

endmodule
